clk_en_rst_seq: RTL
===================

# clk_en_rst_seq

Parametrised clock-enable and reset sequencer replacing free-running per-block clock generators. From one system clock it derives CH_NUM divided clock-enable pulse trains with 50 % duty phase outputs. It also releases per-channel synchronous resets in a staggered order after a power-on delay, and supports a soft-reset request at run time. It sits at the top of each integration next to the global clock input and feeds every downstream clock domain emulated by enables.

## Interface
- CH_NUM, 4, number of output channels (1..16)
- DIV_W, 16, divider counter width
- DIV_INIT, {CH_NUM{16'd2}}, packed reset-time divide ratio per channel
- POR_CYCLES, 64, cycles held in reset after rst_n deasserts (≥1)
- STAGGER, 8, cycles between successive channel reset releases (≥1)

Ports:
- clock  in  1  system clock; sole clock of the block
- rst_n  in  1  asynchronous, active-low reset
- soft_rst_req  in  1  single-cycle request to re-run the release sequence
- div_load  in  CH_NUM  per-channel strobe latching div_value into that channel's shadow register
- div_value  in  DIV_W  shared divide ratio; 0 is treated as 1
- ch_en  out  CH_NUM  one-cycle enable pulse per divided period
- ch_phase  out  CH_NUM  toggles on every ch_en; square wave of period 2×div
- ch_rst_n  out  CH_NUM  synchronous active-low channel reset
- ready  out  1  high while all channels are released
- seq_state  out  2  current FSM state encoding

## Operation
- FSM states: POR(0), RELEASE(1), RUN(2), SOFT(3).
- POR: counter runs POR_CYCLES cycles, then moves to RELEASE.
- RELEASE: step counter from 0. ch_rst_n[i] goes high when step == i×STAGGER. After the last channel is released, moves to RUN.
- RUN: ready=1. A soft_rst_req pulse moves to SOFT.
- SOFT: all ch_rst_n low and ready low for STAGGER cycles, then back to RELEASE.
- soft_rst_req outside RUN is ignored.
- Divider per channel: counter cnt runs 0..div−1 while ch_rst_n[i]=1.
  - ch_en[i]=1 for the cycle in which cnt==div−1.
  - ch_phase[i] toggles on that cycle.
- div_load[i] writes a shadow register. The active ratio updates only at the wrap point (cnt==div−1), so the output is glitch-free.
  - If the channel is held in reset, the shadow is copied to the active ratio immediately.
- Channel in reset: cnt=0, ch_en=0, ch_phase=0.

## Timing
- Reset values (async): seq_state=POR, all ch_en=0, ch_phase=0, ch_rst_n=0, ready=0, active ratios=DIV_INIT, shadows=DIV_INIT.
- All outputs are registered.
- First RELEASE cycle is POR_CYCLES cycles after the first clock edge with rst_n high.
- ch_rst_n[i] high at RELEASE entry + i×STAGGER + 1 cycle (registered).
- ready high one cycle after ch_rst_n[CH_NUM−1].
- First ch_en[i] occurs div cycles after ch_rst_n[i] rises.
- div=1 (or 0): ch_en constantly high, ch_phase toggles every cycle.
- Simultaneous div_load and wrap: old ratio completes the current period; new ratio applies from the next period.
- Two div_load strobes before a wrap: the last value wins.
- soft_rst_req in the same cycle as the RUN entry is accepted.
- rst_n assertion mid-sequence forces all outputs to reset values immediately, independent of the clock.
- Width: cnt is DIV_W bits and compared against active ratio minus 1. The max ratio is 2^DIV_W−1 with no overflow.

## Structure
- Package clk_en_rst_pkg holds:
  - the seq_state_t enum (POR/RELEASE/RUN/SOFT, 2-bit);
  - a function sanitising a ratio (0→1).
- One sub-module, clk_en_div: a single-channel divider with shadow register, instantiated CH_NUM times via generate.
- Sequencer FSM in the top module.

## Test plan
- Power-up, POR_CYCLES=64, STAGGER=8, CH_NUM=4 → ch_rst_n rises at cycles 65, 73, 81, 89 after reset release; ready at 90.
- DIV_INIT ch0=5 → ch_en[0] every 5th cycle, ch_phase[0] period 10; first pulse 5 cycles after ch_rst_n[0] rises.
- Load div_value=3 on ch1 mid-period (ratio 5) → the current 5-cycle period completes, then pulses every 3 cycles; no short pulse.
- div_value=0 loaded on ch2 → ch_en[2] continuously high after the next wrap; ch_phase[2] toggles each cycle.
- soft_rst_req in RUN → seq_state=SOFT and ready=0 next cycle; all ch_rst_n low for 8 cycles; staggered re-release as at power-up.
- rst_n pulled low during RELEASE, between channel 1 and channel 2 release → all outputs 0 asynchronously; full POR sequence reruns after deassertion.

Source files
------------

// File: rtl/clk_en_rst_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
package clk_en_rst_pkg;

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } seq_state_t;

  // A divide ratio of zero behaves as divide-by-one.
  function automatic logic [31:0] ratio_sanitize(input logic [31:0] ratio);
    return (ratio == 32'd0) ? 32'd1 : ratio;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Single-channel clock-enable divider. The ratio is double-buffered: loads
// land in a shadow register and reach the active ratio only at a period
// boundary, or immediately while the channel is held in reset.
module clk_en_div
  import clk_en_rst_pkg::*;
#(
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] RATIO_INIT = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             en,
  output logic             phase
);

  localparam logic [DIV_W-1:0] INIT_SAN = DIV_W'(ratio_sanitize(32'(RATIO_INIT)));

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] shadow_nxt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // Shadow value as it will be after this edge; a load coinciding with a
  // wrap is picked up by the next period, not the one that is ending.
  always_comb begin
    shadow_nxt = shadow;
    if (load) shadow_nxt = DIV_W'(ratio_sanitize(32'(value)));
  end

  assign wrap = (cnt == active - 1'b1);

  // Period counter, enable pulse, phase toggle and ratio hand-over.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= INIT_SAN;
      active <= INIT_SAN;
      cnt    <= '0;
      en     <= 1'b0;
      phase  <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (!run) begin
        cnt    <= '0;
        en     <= 1'b0;
        phase  <= 1'b0;
        active <= shadow_nxt;
      end else if (wrap) begin
        cnt    <= '0;
        en     <= 1'b1;
        phase  <= ~phase;
        active <= shadow_nxt;
      end else begin
        cnt <= cnt + 1'b1;
        en  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_en_rst_seq.sv
// Clock-enable and reset sequencer: holds all channels in reset for a
// power-on delay, releases them one by one, then runs until a soft reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// POR     | power-on delay, all channels in reset
// RELEASE | step counter running, channel i released at step i*STAGGER
// RUN     | all channels released, ready high
// SOFT    | soft reset: all channels back in reset for STAGGER cycles
module clk_en_rst_seq
  import clk_en_rst_pkg::*;
#(
  parameter int                      CH_NUM     = 4,
  parameter int                      DIV_W      = 16,
  parameter logic [CH_NUM*DIV_W-1:0] DIV_INIT   = {CH_NUM{16'd2}},
  parameter int                      POR_CYCLES = 64,
  parameter int                      STAGGER    = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              soft_rst_req,
  input  logic [CH_NUM-1:0] div_load,
  input  logic [DIV_W-1:0]  div_value,
  output logic [CH_NUM-1:0] ch_en,
  output logic [CH_NUM-1:0] ch_phase,
  output logic [CH_NUM-1:0] ch_rst_n,
  output logic              ready,
  output logic [1:0]        seq_state
);

  localparam logic [31:0] LAST_STEP = 32'((CH_NUM - 1) * STAGGER);

  seq_state_t        state;
  logic [31:0]       timer;
  logic [31:0]       step;
  logic [CH_NUM-1:0] rel_hit;

  assign seq_state = state;

  // Channels whose release slot matches the current step.
  always_comb begin
    rel_hit = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rel_hit[i] = (step == 32'(i * STAGGER));
    end
  end

  // Sequencer FSM with down-counting delay timer and up-counting release step.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_POR;
      timer    <= 32'(POR_CYCLES - 1);
      step     <= '0;
      ch_rst_n <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_POR: begin
          if (timer == 32'd0) begin
            state <= ST_RELEASE;
            step  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_RELEASE: begin
          ch_rst_n <= ch_rst_n | rel_hit;
          if (step == LAST_STEP) state <= ST_RUN;
          else                   step  <= step + 1'b1;
        end
        ST_RUN: begin
          if (soft_rst_req) begin
            state    <= ST_SOFT;
            timer    <= 32'(STAGGER - 1);
            ch_rst_n <= '0;
            ready    <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_SOFT: begin
          ch_rst_n <= '0;
          ready    <= 1'b0;
          if (timer == 32'd0) begin
            state <= ST_RELEASE;
            step  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_POR;
      endcase
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    clk_en_div #(
      .DIV_W      (DIV_W),
      .RATIO_INIT (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_div (
      .clock (clock),
      .rst_n (rst_n),
      .run   (ch_rst_n[i]),
      .load  (div_load[i]),
      .value (div_value),
      .en    (ch_en[i]),
      .phase (ch_phase[i])
    );
  end

endmodule
